// File: rtl/i2c_master_byte_engine.sv
// rtl/i2c_master_byte_engine.sv - I2C master single-byte engine with clock-stretch timeout
// Optional arbitration-loss detection is built when I2C_MASTER_ARB_LOST_EN is defined.

module i2c_master_byte_engine #(
    parameter int HALF_PERIOD = 250,
    parameter int STRETCH_MAX = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rd,
    input  logic [7:0] tx_data,
    input  logic       ack_out,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       nack,
    output logic       timeout,
    output logic       arb_lost
);

    localparam int PW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int SW = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;
    localparam logic [PW-1:0] PHASE_LAST   = PW'(HALF_PERIOD - 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'((STRETCH_MAX > 0) ? STRETCH_MAX - 1 : 0);
    localparam bit            STRETCH_EN   = (STRETCH_MAX > 0);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, END} state_t;

    state_t        state, stateNext;
    logic [PW-1:0] phaseCnt;
    logic [SW-1:0] stretchCnt;
    logic [3:0]    bitIdx;
    logic          rdLat;
    logic          ackLat;
    logic [7:0]    txLat;
    logic          holdScl;
    logic          isAck;
    logic [2:0]    dataSel;
    logic          sdaDrive;
    logic          phaseLast;
    logic          firstHigh;
    logic          stretchHit;
    logic          arbHit;
    logic          abortEnd;

    // bitIdx counts down 8..1 for data (MSB first) and 0 for the ACK slot
    assign isAck      = (bitIdx == 4'd0);
    assign dataSel    = 3'(bitIdx - 4'd1);
    assign sdaDrive   = isAck ? (rdLat & ackLat) : (~rdLat & ~txLat[dataSel]);
    assign phaseLast  = (phaseCnt == PHASE_LAST);
    assign firstHigh  = (state == HIGH) && scl_in && (phaseCnt == '0);
    assign stretchHit = STRETCH_EN && (state == HIGH) && !scl_in && (stretchCnt == STRETCH_LAST);

`ifdef I2C_MASTER_ARB_LOST_EN
    logic arbReg;

    // We released SDA for a 1 but the bus reads 0: another master owns it
    assign arbHit   = firstHigh && !rdLat && !isAck && !sdaDrive && !sda_in;
    assign arb_lost = arbReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            arbReg <= 1'b0;
        end else if (state == IDLE && start) begin
            arbReg <= 1'b0;
        end else if (arbHit) begin
            arbReg <= 1'b1;
        end
    end
`else
    assign arbHit   = 1'b0;
    assign arb_lost = 1'b0;
`endif

    assign abortEnd = timeout | arb_lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                scl_oe = holdScl;
                if (start) begin
                    stateNext = LOW;
                end
            end
            LOW: begin
                scl_oe = 1'b1;
                sda_oe = sdaDrive;
                busy   = 1'b1;
                if (phaseLast) begin
                    stateNext = HIGH;
                end
            end
            HIGH: begin
                sda_oe = sdaDrive;
                busy   = 1'b1;
                if (arbHit || stretchHit) begin
                    stateNext = END;
                end else if (scl_in && phaseLast) begin
                    stateNext = isAck ? END : LOW;
                end
            end
            END: begin
                // Keep owning SCL after a clean byte; let go after any abort
                scl_oe    = ~abortEnd;
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phaseCnt   <= '0;
            stretchCnt <= '0;
            bitIdx     <= 4'd0;
            rdLat      <= 1'b0;
            ackLat     <= 1'b0;
            txLat      <= 8'd0;
            rx_data    <= 8'd0;
            nack       <= 1'b0;
            timeout    <= 1'b0;
            holdScl    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rdLat      <= rd;
                        txLat      <= tx_data;
                        ackLat     <= ack_out;
                        rx_data    <= 8'd0;
                        nack       <= 1'b0;
                        timeout    <= 1'b0;
                        bitIdx     <= 4'd8;
                        phaseCnt   <= '0;
                        stretchCnt <= '0;
                    end
                end
                LOW: begin
                    stretchCnt <= '0;
                    phaseCnt   <= phaseLast ? '0 : phaseCnt + 1'b1;
                end
                HIGH: begin
                    if (scl_in) begin
                        if (firstHigh && rdLat && !isAck) begin
                            rx_data <= {rx_data[6:0], sda_in};
                        end
                        if (firstHigh && !rdLat && isAck) begin
                            nack <= sda_in;
                        end
                        if (phaseLast) begin
                            phaseCnt <= '0;
                            if (!isAck) begin
                                bitIdx <= bitIdx - 4'd1;
                            end
                        end else begin
                            phaseCnt <= phaseCnt + 1'b1;
                        end
                    end else if (stretchHit) begin
                        timeout <= 1'b1;
                    end else if (STRETCH_EN) begin
                        stretchCnt <= stretchCnt + 1'b1;
                    end
                end
                END: begin
                    holdScl <= ~abortEnd;
                end
                default: ;
            endcase
        end
    end

endmodule
